// File: rtl/fa_sched_pkg.sv
// Shared types for the shared-adder scheduler: FSM state encoding and datapath width.
// Pure declarations; no logic, no latency, no flow control.
// Imported by fa8_share_sched.
package fa_sched_pkg;

    localparam int FA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        RESP
    } state_t;

endpackage

// File: rtl/fa8_share_sched_rr_arbiter.sv
// Round-robin arbiter: grants the first asserted request at or after ptr, circularly.
// Latency: purely combinational, zero cycles.
// Backpressure: none of its own; the caller decides when the grant is honoured.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx
);

    localparam int IW = $clog2(N);

    int   idx;
    logic found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/fa8_share_sched.sv
// Time-shares one 8-bit ripple-carry adder among NREQ requesters, round-robin.
// Latency: result valid SETTLE_CYC clocks after accept; next accept no sooner than SETTLE_CYC+2.
// Backpressure: one op in flight; req_ready stays low until the response is taken via rsp_ready.
module fa8_share_sched
    import fa_sched_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int SETTLE_CYC = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*FA_W-1:0]     req_a,
    input  logic [NREQ*FA_W-1:0]     req_b,
    input  logic [NREQ-1:0]          req_cin,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic [FA_W-1:0]          rsp_sum,
    output logic                     rsp_cout,
    output logic [FA_W-1:0]          add_a,
    output logic [FA_W-1:0]          add_b,
    output logic                     add_cin,
    input  logic [FA_W-1:0]          add_sum,
    input  logic                     add_cout,
    output logic                     busy
);

    localparam int IDW = $clog2(NREQ);
    localparam int CW  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    state_t          state;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  win_id;
    logic [CW-1:0]   cnt;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_idx;

    rr_arbiter #(.N(NREQ)) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // Gated by rst_n so a requester holding valid through reset never sees a grant.
    assign req_ready = (state == IDLE && rst_n) ? gnt : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            win_id    <= '0;
            cnt       <= '0;
            add_a     <= '0;
            add_b     <= '0;
            add_cin   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // add_* only move on an accept, so the adder sees no idle toggling.
                    if (|gnt) begin
                        add_a   <= req_a[gnt_idx*FA_W +: FA_W];
                        add_b   <= req_b[gnt_idx*FA_W +: FA_W];
                        add_cin <= req_cin[gnt_idx];
                        win_id  <= gnt_idx;
                        cnt     <= CW'(SETTLE_CYC - 1);
                        busy    <= 1'b1;
                        state   <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        rsp_sum   <= add_sum;
                        rsp_cout  <= add_cout;
                        rsp_id    <= win_id;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rr_ptr    <= (win_id == IDW'(NREQ - 1)) ? '0 : win_id + 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
